// File: rtl/reaction_timer_ctrl.sv
// reaction_timer_ctrl: sequences one reaction-game round (arm, lights, timing, result/foul); define BEST_TIME_EN to add best_ms tracking
module reaction_timer_ctrl #(
  parameter int CNT_W  = 14,
  parameter int MAX_MS = 9999
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             start_btn,
  input  logic             react_btn,
  input  logic             time_out,
  output logic             trigger,
  output logic             busy,
  output logic             timing,
  output logic [CNT_W-1:0] result_ms,
  output logic             result_valid,
  output logic             jump_start
`ifdef BEST_TIME_EN
  ,
  output logic [CNT_W-1:0] best_ms
`endif
);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ARM    = 3'd1;
  localparam logic [2:0] S_SEQ    = 3'd2;
  localparam logic [2:0] S_TIMING = 3'd3;
  localparam logic [2:0] S_RESULT = 3'd4;
  localparam logic [2:0] S_FOUL   = 3'd5;
  localparam logic [CNT_W-1:0] MAX = CNT_W'(MAX_MS);
  logic [2:0] state, nxt;
  logic [CNT_W-1:0] cnt;
  logic start_q, react_q, primed, start_rise, react_rise, sat, finish;
  // primed stays low for the first clock after reset so a button held through release is not seen as an edge
  always_comb begin
    start_rise = primed & start_btn & ~start_q;
    react_rise = primed & react_btn & ~react_q;
    sat        = cnt == MAX;
    finish     = state == S_TIMING && (react_rise || sat);
    nxt        = S_IDLE;
    case (state)
      S_IDLE:   nxt = start_rise ? S_ARM : S_IDLE;
      S_ARM:    nxt = S_SEQ;
      S_SEQ:    nxt = react_rise ? S_FOUL : time_out ? S_TIMING : S_SEQ;
      S_TIMING: nxt = finish ? S_RESULT : S_TIMING;
      S_RESULT: nxt = start_rise ? S_ARM : S_RESULT;
      S_FOUL:   nxt = start_rise ? S_ARM : S_FOUL;
      default:  nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      start_q      <= 1'b0;
      react_q      <= 1'b0;
      primed       <= 1'b0;
      cnt          <= '0;
      result_ms    <= '0;
      trigger      <= 1'b0;
      busy         <= 1'b0;
      timing       <= 1'b0;
      result_valid <= 1'b0;
      jump_start   <= 1'b0;
    end else begin
      state        <= nxt;
      start_q      <= start_btn;
      react_q      <= react_btn;
      primed       <= 1'b1;
      trigger      <= nxt == S_ARM;
      busy         <= nxt inside {S_ARM, S_SEQ, S_TIMING};
      timing       <= nxt == S_TIMING;
      result_valid <= nxt == S_RESULT;
      jump_start   <= nxt == S_FOUL;
      if (nxt == S_ARM)
        cnt <= '0;
      else if (state == S_TIMING && tick && !sat)
        cnt <= cnt + 1'b1;
      if (finish)
        result_ms <= cnt;
      else if (nxt == S_ARM || nxt == S_FOUL)
        result_ms <= '0;
    end
  end
`ifdef BEST_TIME_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      best_ms <= MAX;
    else if (finish && cnt < best_ms)
      best_ms <= cnt;
  end
`endif
endmodule

// File: doc/reaction_timer_ctrl.md
Name: reaction_timer_ctrl

Overview:
Sequences one round of the F1-style reaction game. It launches the start-light FSM, watches for a jump-start while the lights and random delay run, then times the player's reaction in milliseconds. Sits above the start-light FSM, LFSR delay and 1 ms tick divider, and feeds the hex-display path with the result or a foul flag.

Parameters:
CNT_W, 14, width of the reaction counter and result outputs
MAX_MS, 9999, saturation value of the counter in ms; must fit in CNT_W bits

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
tick  input  1  one-cycle pulse every 1 ms, synchronous to clk
start_btn  input  1  start request, synchronised level, active high
react_btn  input  1  player button, synchronised level, active high
time_out  input  1  lights-out pulse/level from the random delay; round timing starts here
trigger  output  1  one-cycle pulse that starts the light sequence
busy  output  1  high from trigger until RESULT or FOUL is reached
timing  output  1  high in the TIMING state
result_ms  output  CNT_W  latched reaction time in ms
result_valid  output  1  high while a valid result is held
jump_start  output  1  high while a foul is held

Behaviour:
- Reset: async, active-low. State is IDLE. All outputs are 0, the counter is 0, and the edge-detect registers are 0. This applies mid-round too: assertion aborts at once and no trigger pulse is produced on release.
- Edge detect: start_rise and react_rise are derived from registered copies of the buttons. Only rising edges act; a held button never retriggers.
- IDLE: on start_rise, go to ARM.
- ARM: trigger = 1 for exactly this one cycle; clear the counter; go to SEQ the next cycle.
- SEQ (lights and random delay running, busy = 1):
  - react_rise: go to FOUL.
  - else time_out = 1: go to TIMING with the counter = 0.
  - react_rise and time_out in the same cycle: FOUL wins.
- TIMING (timing = 1, busy = 1):
  - Each tick increments the counter, saturating at MAX_MS.
  - On react_rise: result_ms <= counter value before any same-cycle tick increment; go to RESULT.
  - Counter == MAX_MS with no press: result_ms <= MAX_MS; go to RESULT.
- RESULT: result_valid = 1, busy = 0; result_ms is held. On start_rise, clear result_valid and result_ms and go to ARM.
- FOUL: jump_start = 1, busy = 0, result_ms = 0. On start_rise, clear jump_start and go to ARM.
- start_rise during SEQ or TIMING is ignored.
- Latency:
  - start_rise to trigger: 1 cycle (trigger is registered).
  - react_rise to result_valid: 1 cycle.
- Outputs come from registers. trigger is never high for more than 1 cycle. result_valid and jump_start are mutually exclusive.
- Unused state encodings return to IDLE on the next clk.

Optional Feature:
BEST_TIME_EN
- Defined: adds output best_ms [CNT_W-1:0], reset to MAX_MS.
  - On each entry to RESULT with result < best_ms, best_ms takes the new result. Fouls and saturated results never update it.
  - best_ms survives rounds and is cleared only by rst_n.
- Undefined: no best_ms port and no associated logic.

Test Plan:
- Normal round: start_btn rise → trigger high exactly 1 cycle. time_out. 237 ticks. react_btn rise → result_ms = 237, result_valid = 1 one cycle after the press, busy = 0.
- Jump start: react_btn rise during SEQ → jump_start = 1, result_ms = 0, no TIMING entry. The next start_btn rise clears jump_start and pulses trigger again.
- Tie cases:
  - react_rise and time_out in the same cycle → FOUL.
  - In TIMING, react_rise coincident with the 100th tick → result_ms = 99.
- Saturation: time_out, then no press for MAX_MS+5 ticks → result_ms = 9999 and result_valid = 1 after exactly 9999 ticks.
- Reset mid-round: assert rst_n low during TIMING at count 50 → all outputs 0 asynchronously, state IDLE. Holding start_btn high through reset release produces no trigger until a fresh rising edge.
- BEST_TIME_EN: rounds of 300, 180, 250, then a foul → best_ms = 180 at the end; with the macro undefined the port is absent and the build succeeds.
